// File: rtl/trace_window_ctrl.sv
// Trace window controller: arms on request, waits for a trigger rising edge,
// waits a programmed delay, then holds a dump window open for a programmed
// length or sample limit. A single flush pulse follows every window.
module trace_window_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             arm,
   input  logic             abort,
   input  logic             trig,
   input  logic             sample,
   output logic             dump_en,
   output logic             flush,
   output logic             done,
   output logic             limit_hit,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StArmed = 3'd1;
   localparam logic [2:0] StDelay = 3'd2;
   localparam logic [2:0] StOn    = 3'd3;
   localparam logic [2:0] StFlush = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cfg_delay_q, cfg_delay_d;
   logic [CNT_W-1:0] cfg_len_q, cfg_len_d;
   logic [CNT_W-1:0] cfg_limit_q, cfg_limit_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic             limit_hit_q, limit_hit_d;
   logic             trig_q;
   logic             dump_en_q, flush_q, done_q;

   logic             trig_rise;
   logic [CNT_W:0]   sample_sum;
   logic             limit_match;
   logic             len_expire;

   assign trig_rise = trig & ~trig_q;
   // One extra bit so the limit compare sees the true sum, even at saturation.
   assign sample_sum  = {1'b0, sample_cnt_q} + {{CNT_W{1'b0}}, sample};
   assign limit_match = (cfg_limit_q != '0) && (sample_sum == {1'b0, cfg_limit_q});
   assign len_expire  = (cfg_len_q != '0) && (lcnt_q == CntOne);

   // Next-state and counter/config update logic.
   always_comb begin
      state_d      = state_q;
      cfg_delay_d  = cfg_delay_q;
      cfg_len_d    = cfg_len_q;
      cfg_limit_d  = cfg_limit_q;
      dcnt_d       = dcnt_q;
      lcnt_d       = lcnt_q;
      sample_cnt_d = sample_cnt_q;
      limit_hit_d  = limit_hit_q;

      case (state_q)
         StIdle, StDone: begin
            if (cfg_we) begin
               cfg_delay_d = cfg_delay;
               cfg_len_d   = cfg_len;
               cfg_limit_d = cfg_limit;
            end
            if (arm) begin
               state_d      = StArmed;
               sample_cnt_d = '0;
               limit_hit_d  = 1'b0;
            end
         end
         StArmed: begin
            if (abort) begin
               state_d = StIdle;
            end else if (trig_rise) begin
               if (cfg_delay_q == '0) begin
                  state_d = StOn;
                  lcnt_d  = cfg_len_q;
               end else begin
                  state_d = StDelay;
                  dcnt_d  = cfg_delay_q;
               end
            end
         end
         StDelay: begin
            if (abort) begin
               state_d = StIdle;
            end else if (dcnt_q == CntOne) begin
               state_d = StOn;
               lcnt_d  = cfg_len_q;
            end else begin
               dcnt_d = dcnt_q - CntOne;
            end
         end
         StOn: begin
            // Saturating sample count; the closing cycle's sample still counts.
            sample_cnt_d = sample_sum[CNT_W] ? '1 : sample_sum[CNT_W-1:0];
            lcnt_d       = lcnt_q - CntOne;
            if (limit_match) begin
               limit_hit_d = 1'b1;
            end
            if (abort || limit_match || len_expire) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, config and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cfg_delay_q  <= '0;
         cfg_len_q    <= '0;
         cfg_limit_q  <= '0;
         dcnt_q       <= '0;
         lcnt_q       <= '0;
         sample_cnt_q <= '0;
         limit_hit_q  <= 1'b0;
         trig_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_delay_q  <= cfg_delay_d;
         cfg_len_q    <= cfg_len_d;
         cfg_limit_q  <= cfg_limit_d;
         dcnt_q       <= dcnt_d;
         lcnt_q       <= lcnt_d;
         sample_cnt_q <= sample_cnt_d;
         limit_hit_q  <= limit_hit_d;
         trig_q       <= trig;
      end
   end

   // Registered status strobes decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dump_en_q <= 1'b0;
         flush_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         dump_en_q <= (state_d == StOn);
         flush_q   <= (state_d == StFlush);
         done_q    <= (state_d == StDone);
      end
   end

   assign dump_en    = dump_en_q;
   assign flush      = flush_q;
   assign done       = done_q;
   assign limit_hit  = limit_hit_q;
   assign state      = state_q;
   assign sample_cnt = sample_cnt_q;

endmodule
